// File: rtl/ccff_chain_loader.sv
// Streams a word-serial bitstream into a ccff configuration chain (MSB first).
// Optionally recirculates the chain once afterwards to compare parity.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 10,
    parameter int DW        = 8,
    parameter int CHECK     = 1
) (
    input  logic          prog_clk,
    input  logic          prog_rst_n,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          ccff_head,
    output logic          ccff_shift_en,
    input  logic          ccff_tail,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = $clog2(DW + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [DW-1:0]   r_word;
    logic [BW-1:0]   r_bits;
    logic [CW-1:0]   r_cnt;
    logic            r_lpar, r_cpar, r_err;
    logic            w_start, w_last, w_xfer;

    // r_cnt counts up through LOAD and back down through CHECK, so it never wraps.
    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_last        = 1'b0;
        din_ready     = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_last        = (r_cnt == CW'(CHAIN_LEN - 1));
                ccff_shift_en = (r_bits != '0);
                ccff_head     = ccff_shift_en & r_word[DW-1];
                // No refill on the final chain bit: that word would only be dropped.
                din_ready     = (r_bits == '0) || ((r_bits == BW'(1)) && !w_last);
                if (ccff_shift_en && w_last)
                    w_next = (CHECK != 0) ? S_CHECK : S_DONE;
            end
            S_CHECK: begin
                w_last        = (r_cnt == CW'(1));
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (w_last)
                    w_next = S_DONE;
            end
            default: ;
        endcase
    end

    assign w_xfer = din_valid & din_ready;
    assign busy   = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_word <= '0;
            r_bits <= '0;
            r_cnt  <= '0;
            r_lpar <= 1'b0;
            r_cpar <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_start) begin
            r_bits <= '0;
            r_cnt  <= '0;
            r_lpar <= 1'b0;
            r_cpar <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (ccff_shift_en) begin
                r_lpar <= r_lpar ^ ccff_head;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (ccff_shift_en && w_last) begin
                r_bits <= '0;
            end else if (w_xfer) begin
                r_word <= din;
                r_bits <= BW'(DW);
            end else if (ccff_shift_en) begin
                r_word <= r_word << 1;
                r_bits <= r_bits - BW'(1);
            end
        end else if (r_state == S_CHECK) begin
            r_cpar <= r_cpar ^ ccff_tail;
            r_cnt  <= r_cnt - CW'(1);
            if (w_last)
                r_err <= r_lpar ^ r_cpar ^ ccff_tail;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: a chain shift-register model plus a
// bit-list reference of what the chain must hold and what must recirculate.
module tb_ccff_chain_loader;

    localparam int L  = 10;
    localparam int DW = 8;

    logic          prog_clk = 1'b0;
    logic          prog_rst_n;
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [L-1:0] chain = '0;
    int           nen   = 0;
    logic         hist [0:4095];
    bit           flip_en = 1'b0;
    int           flip_j  = 0;
    int           base_g  = 0;

    ccff_chain_loader #(.CHAIN_LEN(L), .DW(DW), .CHECK(1)) dut (
        .prog_clk      (prog_clk),
        .prog_rst_n    (prog_rst_n),
        .start         (start),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Downstream chain: head enters chain[0], tail leaves chain[L-1].
    assign ccff_tail = chain[L-1] ^ (flip_en && ((nen - base_g) == (L + flip_j)));

    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            hist[nen] <= ccff_head;
            nen       <= nen + 1;
            chain     <= {chain[L-2:0], ccff_head};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!din_ready && n < 100) begin
            @(posedge prog_clk); #1;
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int g0,
                            input int g1, input bit flip, input int fj, input int sp);
        logic [15:0]  ws;
        logic [L-1:0] expv, ec;
        int           stalls, bad, exp_stalls;
        ws = {w0, w1};
        for (int k = 0; k < L; k++) expv[k] = ws[15-k];
        for (int k = 0; k < L; k++) ec[L-1-k] = expv[k] ^ (flip && k == fj);
        exp_stalls = 1 + g0 + ((g1 > DW - 1) ? g1 - (DW - 1) : 0);
        stalls = 0;
        bad    = 0;
        flip_en = flip;
        flip_j  = fj;
        base_g  = nen;
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        fork
            begin
                din_valid = 1'b0;
                repeat (g0) begin @(posedge prog_clk); #1; end
                din = w0; din_valid = 1'b1;
                wait_ready();
                @(posedge prog_clk); #1 din_valid = 1'b0;
                repeat (g1) begin @(posedge prog_clk); #1; end
                din = w1; din_valid = 1'b1;
                wait_ready();
                @(posedge prog_clk); #1 din_valid = 1'b0;
            end
            begin
                if (sp > 0) begin
                    repeat (sp) @(posedge prog_clk);
                    #1 start = 1'b1;
                    @(posedge prog_clk); #1 start = 1'b0;
                end
            end
            begin
                int cyc = 0;
                while (!done && cyc < 300) begin
                    if (busy && !ccff_shift_en) begin
                        stalls++;
                        if (ccff_head) bad++;
                    end
                    @(posedge prog_clk); #1;
                    cyc++;
                end
                if (cyc >= 300) chk("done_timeout", 0, 1);
            end
        join
        chk("n_enabled", nen - base_g, 2 * L);
        for (int k = 0; k < L; k++) chk("load_bit", hist[base_g+k], expv[k]);
        for (int k = 0; k < L; k++)
            chk("recirc_bit", hist[base_g+L+k], expv[k] ^ (flip && k == fj));
        chk("chain", chain, ec);
        chk("stalls", stalls, exp_stalls);
        chk("stall_head", bad, 0);
        chk("end_flags", {busy, done, err}, {2'b01, flip});
        repeat (3) begin @(posedge prog_clk); #1; end
        chk("done_hold", {done, ccff_shift_en, busy}, 3'b100);
        flip_en = 1'b0;
    endtask

    initial begin
        prog_rst_n = 1'b0;
        start      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        #12;
        chk("reset_outs", {din_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
        prog_rst_n = 1'b1;

        // Directed: 0xA5,0xC0 gapless, then tail flip, then long mid-stream stall.
        run_load(8'hA5, 8'hC0, 0, 0, 1'b0, 0, 0);
        run_load(8'hA5, 8'hC0, 0, 0, 1'b1, 3, 0);
        run_load(8'hA5, 8'hC0, 0, 10, 1'b0, 0, 0);
        // Start pulsed mid-load must be ignored.
        run_load(8'h5A, 8'h3F, 1, 2, 1'b0, 0, 5);

        // Reset after 4 shifted bits, then a full reload.
        base_g = nen;
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        din = 8'h3C; din_valid = 1'b1;
        begin
            int n = 0;
            while ((nen - base_g) < 4 && n < 50) begin
                @(posedge prog_clk); #1;
                n++;
            end
            if (n >= 50) chk("rst_wait_timeout", 0, 1);
        end
        prog_rst_n = 1'b0;
        #1;
        chk("rst_outs", {din_ready, ccff_head, ccff_shift_en, busy, done, err}, 0);
        chk("rst_bits", nen - base_g, 4);
        #2 prog_rst_n = 1'b1;
        din_valid = 1'b0;
        run_load(8'hA5, 8'hC0, 0, 0, 1'b0, 0, 0);

        for (int i = 0; i < 6; i++)
            run_load(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 12),
                     1'($urandom_range(0, 1)), $urandom_range(0, L - 1),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
